// File: rtl/fc_partial_sum_accumulator.sv
// Sums per-chunk ALU results for one neuron, saturates to SIZE, applies the activation, and queues outputs.
// Optional macro FC_ACC_RELU_EN selects ReLU; linear activation when it is undefined.
module fc_partial_sum_accumulator #(
  parameter int SIZE       = 16,
  parameter int PRECISION  = 11,
  parameter int ACC_GUARD  = 6,
  parameter int FIFO_DEPTH = 4,
  parameter int BEAT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  input  logic [SIZE-1:0]   i_value,
  input  logic              i_last,
  output logic              o_ready,
  output logic              o_valid,
  output logic [SIZE-1:0]   o_value,
  input  logic              i_ready,
  output logic              o_busy,
  output logic [BEAT_W-1:0] o_beats,
  output logic              o_sat
);

  localparam int ACC_W = SIZE + ACC_GUARD;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic signed [SIZE-1:0]  OUT_MAX = {1'b0, {(SIZE-1){1'b1}}};
  localparam logic signed [SIZE-1:0]  OUT_MIN = {1'b1, {(SIZE-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{ACC_GUARD{1'b0}}, OUT_MAX};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{ACC_GUARD{1'b1}}, OUT_MIN};

  if (PRECISION < 0 || PRECISION >= SIZE) begin : g_bad_precision
    $error("PRECISION must lie in [0, SIZE-1]");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                  state_reg, state_next;
  logic signed [ACC_W-1:0] acc_reg, acc_next;
  logic signed [ACC_W-1:0] ext_value, sum;
  logic [BEAT_W-1:0]       beats_reg, beats_next;
  logic                    sat_reg, sat_next;
  logic signed [SIZE-1:0]  clamped, result;
  logic                    clamp_hi, clamp_lo;
  logic                    accept, push, pop, fifo_full, fifo_empty;

  logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]        count_reg;
  logic [SIZE-1:0]         mem [FIFO_DEPTH];

  // Ready depends only on the registered count, so i_ready never reaches o_ready.
  assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_reg == '0);
  assign o_ready    = !fifo_full;
  assign accept     = i_valid && o_ready;
  assign push       = accept && i_last;
  assign pop        = !fifo_empty && i_ready;

  assign ext_value = {{ACC_GUARD{i_value[SIZE-1]}}, i_value};
  assign sum       = acc_reg + ext_value;
  assign clamp_hi  = (sum > SAT_MAX);
  assign clamp_lo  = (sum < SAT_MIN);

  always_comb begin
    clamped = sum[SIZE-1:0];
    if (clamp_hi) begin
      clamped = OUT_MAX;
    end else if (clamp_lo) begin
      clamped = OUT_MIN;
    end
  end

`ifdef FC_ACC_RELU_EN
  assign result = clamped[SIZE-1] ? '0 : clamped;
`else
  assign result = clamped;
`endif

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    beats_next = beats_reg;
    sat_next   = sat_reg;
    if (accept) begin
      if (i_last) begin
        state_next = IDLE;
        acc_next   = '0;
        beats_next = '0;
        if (clamp_hi || clamp_lo) begin
          sat_next = 1'b1;
        end
      end else begin
        state_next = ACCUM;
        acc_next   = sum;
        if (beats_reg != '1) begin
          beats_next = beats_reg + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      beats_reg <= '0;
      sat_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      beats_reg <= beats_next;
      sat_reg   <= sat_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= result;
    end
  end

  assign o_valid = !fifo_empty;
  assign o_value = fifo_empty ? '0 : mem[rd_ptr_reg];
  assign o_busy  = (state_reg == ACCUM);
  assign o_beats = beats_reg;
  assign o_sat   = sat_reg;

endmodule

// File: tb/tb_fc_partial_sum_accumulator.sv
// Bench for fc_partial_sum_accumulator: directed plan steps plus random neurons against a queue-based model.
module tb_fc_partial_sum_accumulator;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [15:0] i_value = '0;
  logic        i_last = 1'b0;
  logic        o_ready;
  logic        o_valid;
  logic [15:0] o_value;
  logic        i_ready = 1'b1;
  logic        o_busy;
  logic [7:0]  o_beats;
  logic        o_sat;

  int checks = 0;
  int failures = 0;

  // Reference model: neuron running sum, beat count, sticky flag, FIFO as a queue.
  logic [15:0] exp_q[$];
  logic [15:0] popped[$];
  int          m_sum = 0;
  int          m_beats = 0;
  bit          m_sat = 0;
  bit          m_busy = 0;
  bit          m_accepted = 0;
  bit          rand_ready = 0;

  fc_partial_sum_accumulator dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid),
    .i_value (i_value),
    .i_last  (i_last),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .o_value (o_value),
    .i_ready (i_ready),
    .o_busy  (o_busy),
    .o_beats (o_beats),
    .o_sat   (o_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock, updating the model from the inputs presented before the edge.
  task automatic cycle();
    bit take;
    bit drop;
    int s;
    if (rand_ready) i_ready = 1'($urandom_range(0, 1));
    m_accepted = 0;
    if (!rst_n) begin
      exp_q.delete();
      m_sum = 0;
      m_beats = 0;
      m_sat = 0;
      m_busy = 0;
    end else begin
      drop = (exp_q.size() > 0) && i_ready;
      take = i_valid && (exp_q.size() < DEPTH);
      if (drop) begin
        popped.push_back(o_value);
        void'(exp_q.pop_front());
      end
      if (take) begin
        m_accepted = 1;
        s = m_sum + int'($signed(i_value));
        if (i_last) begin
          if (s > 32767) begin
            s = 32767;
            m_sat = 1;
          end else if (s < -32768) begin
            s = -32768;
            m_sat = 1;
          end
`ifdef FC_ACC_RELU_EN
          if (s < 0) s = 0;
`endif
          exp_q.push_back(16'(s));
          m_sum = 0;
          m_beats = 0;
          m_busy = 0;
        end else begin
          m_sum = s;
          if (m_beats < 255) m_beats++;
          m_busy = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("o_valid", 32'(o_valid), 32'(exp_q.size() > 0));
    chk("o_value", 32'(o_value), (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'h0);
    chk("o_ready", 32'(o_ready), 32'(exp_q.size() < DEPTH));
    chk("o_busy", 32'(o_busy), 32'(m_busy));
    chk("o_beats", 32'(o_beats), 32'(m_beats));
    chk("o_sat", 32'(o_sat), 32'(m_sat));
  endtask

  task automatic send(input logic [15:0] v, input logic l);
    int n = 0;
    i_valid = 1'b1;
    i_value = v;
    i_last = l;
    do begin
      cycle();
      n++;
    end while (!m_accepted && n < 100);
    if (!m_accepted) chk("accept_timeout", 32'h0, 32'h1);
    i_valid = 1'b0;
    i_last = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    i_valid = 1'b0;
    for (int k = 0; k < n; k++) cycle();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    i_ready = 1'b1;
    while (exp_q.size() > 0 && n < 50) begin
      cycle();
      n++;
    end
    chk("drain_empty", 32'(o_valid), 32'h0);
  endtask

  initial begin
    // Reset state
    do_reset(2);
    chk("rst_o_ready", 32'(o_ready), 32'h1);
    chk("rst_o_valid", 32'(o_valid), 32'h0);

    // Three-beat neuron
    i_ready = 1'b1;
    send(16'h0800, 1'b0);
    chk("busy_after_first", 32'(o_busy), 32'h1);
    send(16'h0400, 1'b0);
    chk("beats_before_last", 32'(o_beats), 32'h2);
    send(16'h0200, 1'b1);
    chk("three_beat_valid", 32'(o_valid), 32'h1);
    chk("three_beat_value", 32'(o_value), 32'h0E00);
    cycle();

    // Saturation, then a clean neuron with the flag still held
    send(16'h7000, 1'b0);
    send(16'h7000, 1'b1);
    chk("sat_value", 32'(o_value), 32'h7FFF);
    chk("sat_flag", 32'(o_sat), 32'h1);
    send(16'h0100, 1'b1);
    chk("clean_value", 32'(o_value), 32'h0100);
    chk("sat_sticky", 32'(o_sat), 32'h1);
    cycle();

    // Negative single-beat neuron from a fresh reset
    do_reset(1);
    send(16'hF800, 1'b1);
`ifdef FC_ACC_RELU_EN
    chk("neg_value", 32'(o_value), 32'h0000);
`else
    chk("neg_value", 32'(o_value), 32'hF800);
`endif
    chk("neg_sat", 32'(o_sat), 32'h0);
    cycle();

    // Backpressure: four fill the FIFO, fifth waits
    i_ready = 1'b0;
    for (int k = 1; k <= 4; k++) send(16'(k), 1'b1);
    chk("full_not_ready", 32'(o_ready), 32'h0);
    i_valid = 1'b1;
    i_value = 16'h0005;
    i_last = 1'b1;
    for (int k = 0; k < 3; k++) cycle();
    chk("held_not_ready", 32'(o_ready), 32'h0);
    popped.delete();
    i_ready = 1'b1;
    cycle();
    chk("ready_after_pop", 32'(o_ready), 32'h1);
    cycle();
    i_valid = 1'b0;
    i_last = 1'b0;
    drain();
    chk("bp_count", 32'(popped.size()), 32'h5);
    for (int k = 0; k < popped.size() && k < 5; k++) chk("bp_order", 32'(popped[k]), 32'(k + 1));

    // Reset mid-accumulate discards the partial sum
    send(16'h0100, 1'b0);
    do_reset(1);
    popped.delete();
    send(16'h0100, 1'b1);
    chk("mid_rst_value", 32'(o_value), 32'h0100);
    drain();
    chk("mid_rst_count", 32'(popped.size()), 32'h1);

    // Beat counter saturates at its maximum
    for (int k = 0; k < 260; k++) send(16'h0000, 1'b0);
    chk("beats_saturate", 32'(o_beats), 32'hFF);
    send(16'h0005, 1'b1);
    chk("long_neuron_value", 32'(o_value), 32'h0005);
    drain();

    // Random neurons with random gaps and random downstream readiness
    rand_ready = 1;
    for (int n = 0; n < 150; n++) begin
      int gap;
      int len;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) cycle();
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) send(16'($urandom), 1'(b == len - 1));
    end
    rand_ready = 0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fc_partial_sum_accumulator.md
Name: fc_partial_sum_accumulator

Overview:
Downstream stage of the fully-connected MAC ALU.
- Consumes the ALU's per-chunk fixed-point result (bias plus INPUT_SZ products), one beat per chunk.
- Sums chunks belonging to one neuron in a guarded accumulator, then saturates to SIZE and applies the activation.
- Buffers finished neuron outputs in a small FIFO with valid/ready output handshake toward the layer output writer.

Parameters:
SIZE, 16, data width; signed two's complement, PRECISION fractional bits
PRECISION, 11, fractional bits (Q5.11 default); informational only, no rescaling performed
ACC_GUARD, 6, extra accumulator MSBs; accumulator width = SIZE+ACC_GUARD
FIFO_DEPTH, 4, output FIFO entries; power of two, >=2
BEAT_W, 8, width of per-neuron beat counter

Ports:
clk  input  1  clock, all logic on posedge
rst_n  input  1  synchronous active-low reset
i_valid  input  1  upstream beat valid
i_value  input  SIZE  ALU chunk result, signed
i_last  input  1  beat is final chunk of current neuron
o_ready  output  1  beat accepted when i_valid && o_ready
o_valid  output  1  FIFO head valid
o_value  output  SIZE  finished neuron output
i_ready  input  1  downstream accepts head when o_valid && i_ready
o_busy  output  1  high while a neuron is partially accumulated
o_beats  output  BEAT_W  beats accepted for current neuron, saturating
o_sat  output  1  sticky saturation flag

Behaviour:
- Reset (synchronous, active low, one clock clk): acc=0, FIFO empty, state IDLE.
- Outputs after reset: o_valid=0, o_value=0, o_busy=0, o_beats=0, o_sat=0, o_ready=1.
- Reset mid-operation discards partial sum and all FIFO contents.
- o_ready = !fifo_full, a function of registered state only.
  - No combinational path from i_ready to o_ready.
  - Conservative: o_ready is low when the FIFO is full even for non-last beats.
- FSM, two states:
  - IDLE: accepted beat with i_last=0 -> ACCUM; accepted beat with i_last=1 -> stays IDLE, pushes result.
  - ACCUM: accepted beat with i_last=1 -> IDLE, pushes result; otherwise stays ACCUM.
  - o_busy = (state==ACCUM).
- Accumulate: sum = acc + sign_extend(i_value) at width SIZE+ACC_GUARD.
  - Non-last beat: acc<=sum, o_beats increments, saturating at 2^BEAT_W-1.
  - Last beat: result = clamp(sum) to [-2^(SIZE-1), 2^(SIZE-1)-1]; activation applied (see Optional Feature); pushed to FIFO; acc<=0, o_beats<=0.
- Guard-bit overflow: the accumulator wraps.
  - Wrap is not detected; the upstream sequencer bounds chunk count to 2^ACC_GUARD.
- Clamp engaged: o_sat<=1, held until reset.
- Latency: result visible on o_value with o_valid=1 on the cycle after the accepting edge of the last beat, when the FIFO was empty.
- FIFO:
  - Order preserved.
  - Push and pop in the same cycle allowed, including at full-1 and when non-empty.
  - Pop on empty is a no-op.
  - o_value stable while o_valid && !i_ready.
  - o_ready rises the cycle after a pop from full.
- i_valid && !o_ready: beat not consumed; upstream holds i_value/i_last.

Optional Feature:
Macro FC_ACC_RELU_EN.
- Defined: clamped result < 0 is replaced by 0 before push. o_sat still reflects the clamp only, not ReLU.
- Undefined: clamped signed result is pushed unchanged (linear activation).

Test Plan:
- Reset: rst_n low 2 cycles, i_valid=0 -> o_valid=0, o_ready=1, o_busy=0, o_beats=0, o_sat=0.
- Three-beat neuron, i_ready=1:
  - Beats 0x0800, 0x0400, 0x0200(last) -> o_busy=1 after first beat, o_beats=2 before last.
  - Single output 0x0E00 with o_valid one cycle after last accept.
- Saturation: 0x7000, 0x7000(last) -> output 0x7FFF, o_sat=1, still 1 after next clean neuron 0x0100(last) -> 0x0100.
- Negative single-beat neuron 0xF800(last):
  - FC_ACC_RELU_EN defined -> output 0x0000.
  - Undefined -> output 0xF800.
  - o_sat=0 in both builds.
- Backpressure: i_ready=0, single-beat neurons 0x0001..0x0005 offered back-to-back.
  - Four accepted, o_ready=0 after fourth, fifth held.
  - Raise i_ready -> outputs 0x0001..0x0005 in order, no loss or duplicate, o_ready=1 the cycle after first pop.
- Reset mid-accumulate: 0x0100(non-last), rst_n low 1 cycle, then 0x0100(last) -> exactly one output 0x0100, no stale data.
